// File: rtl/series_pkg.sv
// series_pkg: shared definitions for the power-series controller.
//   state_t           controller state encoding
//   MODE_*            function select codes on the mode input
//   SEL_*             datapath operation codes on the sel output
//   mode_is_odd/sq/alt  per-function series properties
package series_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_MUL,
        S_INC1,
        S_DIV1,
        S_INC2,
        S_DIV2,
        S_ACC,
        S_CHK,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_EXP  = 2'd0;
    localparam logic [1:0] MODE_SIN  = 2'd1;
    localparam logic [1:0] MODE_COS  = 2'd2;
    localparam logic [1:0] MODE_SINH = 2'd3;

    localparam logic [1:0] SEL_MUL = 2'd0;
    localparam logic [1:0] SEL_DIV = 2'd1;
    localparam logic [1:0] SEL_ACC = 2'd2;

    // Odd series (sin, sinh): t and r start at x, c starts at 1.
    function automatic logic mode_is_odd(input logic [1:0] m);
        return (m == MODE_SIN) || (m == MODE_SINH);
    endfunction

    // Step is x*x and each term takes two counter/divide passes.
    function automatic logic mode_is_sq(input logic [1:0] m);
        return (m != MODE_EXP);
    endfunction

    // Alternating-sign series (sin, cos).
    function automatic logic mode_is_alt(input logic [1:0] m);
        return (m == MODE_SIN) || (m == MODE_COS);
    endfunction

endpackage

// File: rtl/series_term_counter.sv
// series_term_counter: counts accumulated terms k.
//   clk, rst   clock, asynchronous active-low reset
//   clr        synchronous clear of k
//   inc        k <= k + 1
//   k_lsb      k[0], used for the alternating sign
//   k_max      k == MAX_TERMS
module series_term_counter #(
    parameter int MAX_TERMS = 8,
    parameter int K_W       = $clog2(MAX_TERMS + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic k_lsb,
    output logic k_max
);

    localparam logic [K_W-1:0] K_LAST = K_W'(MAX_TERMS);

    logic [K_W-1:0] k;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k <= '0;
        end else if (clr) begin
            k <= '0;
        end else if (inc) begin
            k <= k + K_W'(1);
        end
    end

    assign k_lsb = k[0];
    assign k_max = (k == K_LAST);

endmodule

// File: rtl/series_ctrl_p.sv
// series_ctrl_p: sequencer for the iterative power-series datapath.
//   clk, rst                 clock, asynchronous active-low reset
//   start, abort             run request (IDLE only), synchronous abort
//   mode[1:0]                0 exp, 1 sin, 2 cos, 3 sinh
//   lt                       datapath small-term flag, sampled in CHK
//   init_t/init_r/init_c     initialise term, result and counter registers
//   t_odd, ld_x, xsq         initial-value select, step load, step = x*x
//   ld_t, ld_r, cnt          term load, result load, c <= c+1
//   sel[1:0], sub            datapath operation, subtract on accumulate
//   ready, done, limit       idle, completion pulse, ended on term limit
module series_ctrl_p
    import series_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int K_W       = $clog2(MAX_TERMS + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] mode,
    input  logic       lt,
    output logic       init_t,
    output logic       init_r,
    output logic       init_c,
    output logic       t_odd,
    output logic       ld_x,
    output logic       xsq,
    output logic       ld_t,
    output logic       ld_r,
    output logic       cnt,
    output logic [1:0] sel,
    output logic       sub,
    output logic       ready,
    output logic       done,
    output logic       limit
);

    state_t     state, state_n;
    logic [1:0] mode_q;
    logic       limit_q;
    logic       k_lsb, k_max;

    logic f_odd, f_sq, f_alt;
    assign f_odd = mode_is_odd(mode_q);
    assign f_sq  = mode_is_sq(mode_q);
    assign f_alt = mode_is_alt(mode_q);

    series_term_counter #(
        .MAX_TERMS (MAX_TERMS),
        .K_W       (K_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == S_INIT),
        .inc   (state == S_ACC),
        .k_lsb (k_lsb),
        .k_max (k_max)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            mode_q  <= MODE_EXP;
            limit_q <= 1'b0;
        end else begin
            state <= state_n;
            // Mode is captured on the edge that accepts start, so every
            // output during INIT is already decoded from registered state.
            if (state == S_IDLE && start) begin
                mode_q <= mode;
            end
            if (state == S_CHK) begin
                limit_q <= !lt && k_max;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n = state;
        init_t  = 1'b0;
        init_r  = 1'b0;
        init_c  = 1'b0;
        t_odd   = 1'b0;
        ld_x    = 1'b0;
        xsq     = 1'b0;
        ld_t    = 1'b0;
        ld_r    = 1'b0;
        cnt     = 1'b0;
        sel     = SEL_MUL;
        sub     = 1'b0;
        ready   = 1'b0;
        done    = 1'b0;
        limit   = 1'b0;

        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_n = S_INIT;
            end
            S_INIT: begin
                init_t  = 1'b1;
                init_r  = 1'b1;
                init_c  = 1'b1;
                ld_x    = 1'b1;
                t_odd   = f_odd;
                xsq     = f_sq;
                state_n = S_MUL;
            end
            S_MUL: begin
                ld_t    = 1'b1;
                sel     = SEL_MUL;
                state_n = S_INC1;
            end
            S_INC1: begin
                cnt     = 1'b1;
                state_n = S_DIV1;
            end
            S_DIV1: begin
                ld_t    = 1'b1;
                sel     = SEL_DIV;
                state_n = f_sq ? S_INC2 : S_ACC;
            end
            S_INC2: begin
                cnt     = 1'b1;
                state_n = S_DIV2;
            end
            S_DIV2: begin
                ld_t    = 1'b1;
                sel     = SEL_DIV;
                state_n = S_ACC;
            end
            S_ACC: begin
                ld_r    = 1'b1;
                sel     = SEL_ACC;
                // k is still the pre-increment count here: even k subtracts,
                // so the first accumulated term is negative.
                sub     = f_alt && !k_lsb;
                state_n = S_CHK;
            end
            S_CHK: begin
                if (lt || k_max) state_n = S_DONE;
                else             state_n = S_MUL;
            end
            S_DONE: begin
                done    = 1'b1;
                limit   = limit_q;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        if (abort && state != S_IDLE) begin
            state_n = S_IDLE;
        end
    end

endmodule

// File: tb/tb_series_ctrl_p.sv
// tb_series_ctrl_p: self-checking bench for series_ctrl_p.
// Expected timing, sign pattern and termination are derived from the
// function's series properties and plain arithmetic (done at 1+P*N).
module tb_series_ctrl_p;
    import series_pkg::*;

    localparam int MAXT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, abort = 1'b0, lt = 1'b0;
    logic [1:0] mode = 2'd0;
    logic init_t, init_r, init_c, t_odd, ld_x, xsq, ld_t, ld_r, cnt, sub, ready, done, limit;
    logic [1:0] sel;

    // Second instance with a single-term limit.
    logic start1 = 1'b0;
    logic [1:0] mode1 = 2'd0;
    logic init_t1, init_r1, init_c1, t_odd1, ld_x1, xsq1, ld_t1, ld_r1, cnt1, sub1, ready1, done1, limit1;
    logic [1:0] sel1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    series_ctrl_p #(.MAX_TERMS(MAXT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .lt(lt),
        .init_t(init_t), .init_r(init_r), .init_c(init_c), .t_odd(t_odd),
        .ld_x(ld_x), .xsq(xsq), .ld_t(ld_t), .ld_r(ld_r), .cnt(cnt),
        .sel(sel), .sub(sub), .ready(ready), .done(done), .limit(limit)
    );

    series_ctrl_p #(.MAX_TERMS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .mode(mode1), .lt(1'b0),
        .init_t(init_t1), .init_r(init_r1), .init_c(init_c1), .t_odd(t_odd1),
        .ld_x(ld_x1), .xsq(xsq1), .ld_t(ld_t1), .ld_r(ld_r1), .cnt(cnt1),
        .sel(sel1), .sub(sub1), .ready(ready1), .done(done1), .limit(limit1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] outs();
        return {init_t, init_r, init_c, t_odd, ld_x, xsq, ld_t, ld_r, cnt, sel, sub, done, limit};
    endfunction

    // One evaluation from IDLE. lt rises once the lt_term-th term has been
    // accumulated (lt_term = 0: lt high throughout).
    task automatic run_eval(input logic [1:0] m, input int lt_term);
        int p, n, nacc, last;
        logic exp_limit, alt, odd, sq;
        p    = (m == MODE_EXP) ? 5 : 7;
        odd  = (m == MODE_SIN) || (m == MODE_SINH);
        sq   = (m != MODE_EXP);
        alt  = (m == MODE_SIN) || (m == MODE_COS);
        if (lt_term == 0)         begin n = 1;         exp_limit = 1'b0; end
        else if (lt_term <= MAXT) begin n = lt_term;   exp_limit = 1'b0; end
        else                      begin n = MAXT;      exp_limit = 1'b1; end
        last = 1 + p * n;

        mode  = m;
        start = 1'b1;
        lt    = (lt_term == 0);
        step();                         // edge 0
        start = 1'b0;
        check("init_strobes", {init_t, init_r, init_c, ld_x}, 4'hf);
        check("init_t_odd", t_odd, odd);
        check("init_xsq", xsq, sq);

        nacc = 0;
        for (int e = 1; e <= last; e++) begin
            lt = (lt_term == 0) || ((e - 1) >= p * lt_term);
            step();
            if (ld_r) begin
                nacc++;
                check("acc_sel", sel, SEL_ACC);
                check($sformatf("acc_sub_%0d", nacc), sub, alt && (nacc % 2 == 1));
            end
            check($sformatf("done_e%0d", e), done, (e == last));
            if (e == last) check("limit", limit, exp_limit);
        end
        check("acc_count", nacc, n);
        lt = 1'b0;
        step();
        check("ready_after", {ready, done}, 2'b10);
    endtask

    initial begin
        int dcount, nacc1;

        // Reset state
        #2;
        check("reset_outs", outs(), 14'h0);
        check("reset_ready", ready, 1'b1);
        #10 rst = 1'b1;
        step();
        check("idle_ready", ready, 1'b1);

        // Abort held in IDLE is ignored; start alone is required to leave.
        abort = 1'b1;
        step();
        check("idle_abort", ready, 1'b1);
        abort = 1'b0;

        // Directed cases from the function list
        run_eval(MODE_EXP, MAXT + 1);    // term limit, done after edge 41
        run_eval(MODE_SIN, 3);           // lt after 3rd ACC, done after edge 22
        run_eval(MODE_COS, 0);           // lt constant, one term, done after edge 8
        run_eval(MODE_SINH, MAXT);       // lt and limit together: lt wins

        // Abort in DIV2 of term 2 (sinh)
        mode  = MODE_SINH;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 12; e++) step();
        check("div2_sel", {ld_t, sel}, {1'b1, SEL_DIV});
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle", {ready, done}, 2'b10);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) dcount++;
        end
        check("abort_no_done", dcount, 0);
        run_eval(MODE_SINH, 2);

        // Asynchronous reset in the middle of ACC (sin: ACC after edge 6)
        mode  = MODE_SIN;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 6; e++) step();
        check("pre_rst_acc", ld_r, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rst_outs", outs(), 14'h0);
        check("rst_ready", ready, 1'b1);
        #1 rst = 1'b1;
        step();
        check("post_rst_idle", {ready, done}, 2'b10);

        // Start held across DONE: one IDLE cycle, then INIT again
        mode  = MODE_EXP;
        lt    = 1'b1;
        start = 1'b1;
        step();
        for (int e = 1; e <= 6; e++) step();
        check("held_done", done, 1'b1);
        step();
        check("held_idle", {ready, init_t}, 2'b10);
        step();
        check("held_init", {ready, init_t}, 2'b01);
        start = 1'b0;
        lt    = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("held_abort_idle", ready, 1'b1);

        // MAX_TERMS=1: mode changes after acceptance must be ignored
        mode1  = MODE_SIN;
        start1 = 1'b1;
        step();                          // edge 0 -> INIT
        start1 = 1'b0;
        check("m1_init_xsq", xsq1, 1'b1);
        nacc1  = 0;
        dcount = 0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 1) mode1 = MODE_EXP;   // change while in MUL
            if (ld_r1) begin
                nacc1++;
                check("m1_sub", sub1, 1'b1);
            end
            if (done1) begin
                dcount++;
                check("m1_done_edge", e, 8);
                check("m1_limit", limit1, 1'b1);
            end
        end
        check("m1_done_count", dcount, 1);
        check("m1_acc_count", nacc1, 1);
        step();
        check("m1_ready", ready1, 1'b1);

        // Randomized evaluations against the model
        for (int i = 0; i < 8; i++) begin
            run_eval(2'($urandom_range(0, 3)), int'($urandom_range(0, MAXT + 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
